dpram_read_streamer: RTL
========================

// Module: dpram_read_streamer
// PURPOSE
//  Read-side sequencer for the 1024x64 dual-port RAM. On a start pulse it reads
//  LENGTH consecutive words from BASE (wrapping mod NUM_WORDS) through one RAM port.
//  It presents them as a valid/ready stream to the downstream compute stage.
//  It absorbs the RAM's 1-cycle read latency and downstream backpressure with a 2-entry skid FIFO.
// PARAMETERS
//  AWIDTH     10    RAM address width
//  NUM_WORDS  1024  RAM depth; addresses wrap at NUM_WORDS-1 -> 0
//  DWIDTH     64    RAM / stream data width
// PORTS
//  clk          in   1         single clock, all logic rising-edge
//  reset        in   1         asynchronous, active-high reset
//  start        in   1         1-cycle request pulse; sampled only in IDLE
//  base_addr    in   AWIDTH    first word address, captured on accepted start
//  length       in   AWIDTH+1  word count 0..NUM_WORDS, captured on accepted start
//  busy         out  1         high from accepted start until done
//  done         out  1         1-cycle pulse after the last word leaves the stream
//  ram_address  out  AWIDTH    to RAM address_a
//  ram_wren     out  1         to RAM wren_a; constant 0
//  ram_rdata    in   DWIDTH    from RAM out_a; valid 1 cycle after address presented
//  out_data     out  DWIDTH    stream data (head of skid FIFO)
//  out_valid    out  1         stream valid
//  out_ready    in   1         downstream ready; transfer when out_valid & out_ready
// BEHAVIOUR
//  Reset values (async): state=IDLE, busy=0, done=0, ram_address=0, ram_wren=0,
//   out_valid=0, out_data=0, FIFO empty, in-flight flag=0, counters=0.
//  FSM states IDLE, RUN, DRAIN:
//   IDLE : start & length!=0 -> RUN; addr<=base_addr, remaining<=length, busy<=1.
//          start & length==0 -> done pulses next cycle, busy stays 0, no RAM reads.
//          start is ignored in RUN and DRAIN; no queueing.
//   RUN  : a read issue is a cycle with ram_address=addr and issue=1.
//          Issue only when occupancy+in_flight < 2. occupancy includes this cycle's pop.
//          On each issue: addr<=addr+1 mod NUM_WORDS, remaining<=remaining-1.
//          Last issue (remaining==1) -> DRAIN.
//   DRAIN: wait until in_flight==0 and the FIFO is empty after the final pop.
//          Then done<=1 for 1 cycle, busy<=0, state->IDLE.
//  Read latency: a word issued at cycle t is written into the FIFO at t+1 (in_flight=1 during t+1).
//  Minimum latency start->first out_valid is 3 cycles (capture, issue, RAM, FIFO write).
//  FIFO: 2 entries, push from RAM return, pop on out_valid&out_ready.
//   Simultaneous push+pop keeps occupancy unchanged.
//   out_valid = occupancy!=0; out_data is the oldest entry.
//   It never overflows: the credit rule guarantees occupancy+in_flight<=2.
//  Throughput: 1 word/cycle sustained while out_ready=1. Back-to-back jobs have a 1-cycle IDLE gap.
//  Data order equals address order. Wrap example: base 1022, length 4 reads 1022, 1023, 0, 1.
//  length==NUM_WORDS reads every word exactly once, starting at base.
//  Backpressure: out_ready may drop any cycle.
//   While out_valid=1 and out_ready=0, out_data is held stable.
//   Issue stalls once the credit is exhausted.
//  Reset mid-job aborts immediately: no done pulse, FIFO contents discarded.
//   A RAM return arriving after reset release is ignored.
//  ram_wren is tied 0. The writer owns the other RAM port.
// TESTING
//  1 Reset, then start base=0 len=4 with out_ready=1 and RAM holding addr*3.
//    -> out_data 0,3,6,9 on consecutive cycles; done 1 cycle after the last beat; busy low after.
//  2 start base=1022 len=4
//    -> ram_address sequence 1022,1023,0,1; stream data matches those words in order.
//  3 len=8 with out_ready toggling 1,0,0,1,...
//    -> no beat lost or duplicated; out_data stable while stalled; at most 2 reads outstanding.
//  4 start with len=0 -> done pulse, busy never high, ram_address never advances.
//    start pulsed during RUN -> ignored.
//  5 len=1024, out_ready=1 -> exactly 1024 beats in 1024 consecutive cycles, then done.
//  6 Assert reset mid-job after 5 beats -> out_valid=0 and busy=0 immediately.
//    A new start base=0 len=2 yields exactly 2 beats.

Source files
------------

// File: rtl/dpram_read_streamer.sv
// Read-side sequencer for the 1024x64 dual-port RAM: reads a block of
// consecutive words (wrapping at the top of memory) and streams them out
// through a 2-entry skid FIFO with valid/ready handshaking.
module dpram_read_streamer #(
  parameter int unsigned AWIDTH    = 10,
  parameter int unsigned NUM_WORDS = 1024,
  parameter int unsigned DWIDTH    = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic [AWIDTH:0]   length,
  output logic              busy,
  output logic              done,
  output logic [AWIDTH-1:0] ram_address,
  output logic              ram_wren,
  input  logic [DWIDTH-1:0] ram_rdata,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int unsigned CW = AWIDTH + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state;
  state_t              state_next;
  logic [AWIDTH:0]     remaining;
  logic                in_flight;
  logic [1:0]          count;
  logic [DWIDTH-1:0]   tail;
  logic                pop;
  logic                push;
  logic [2:0]          count_after_pop;
  logic [2:0]          count_next;
  logic                credit;
  logic                issue;
  logic                load;
  logic                busy_next;
  logic                done_next;

  // The other RAM port belongs to the writer; this port only reads.
  assign ram_wren = 1'b0;

  // FIFO bookkeeping; the credit counts the pop happening this cycle.
  always_comb begin
    pop             = out_valid & out_ready;
    push            = in_flight;
    count_after_pop = {1'b0, count} - 3'(pop);
    count_next      = count_after_pop + 3'(push);
    credit          = (count_after_pop + 3'(in_flight)) < 3'd2;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and control decode.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    load       = 1'b0;
    busy_next  = busy;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            state_next = RUN;
            load       = 1'b1;
            busy_next  = 1'b1;
          end else begin
            done_next  = 1'b1;
          end
        end
      end
      RUN: begin
        if (credit) begin
          issue = 1'b1;
          if (remaining == CW'(1)) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!in_flight && count_next == 3'd0) begin
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Address/length counters, status flags and read-return tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_address <= '0;
      remaining   <= '0;
      in_flight   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      busy      <= busy_next;
      done      <= done_next;
      in_flight <= issue;
      if (load) begin
        ram_address <= base_addr;
        remaining   <= length;
      end else if (issue) begin
        ram_address <= (ram_address == AWIDTH'(NUM_WORDS - 1)) ? '0 : ram_address + AWIDTH'(1);
        remaining   <= remaining - CW'(1);
      end
    end
  end

  // Two-entry skid FIFO; out_data is the head entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      tail      <= '0;
    end else begin
      count     <= 2'(count_next);
      out_valid <= (count_next != 3'd0);
      case (count)
        2'd0: if (push) out_data <= ram_rdata;
        2'd1: begin
          if (push && pop) out_data <= ram_rdata;
          else if (push)   tail     <= ram_rdata;
        end
        2'd2: begin
          if (pop) begin
            out_data <= tail;
            if (push) tail <= ram_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
